// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the integer ALU.
// Holds decoded ops until both operands resolve (from dispatch or by CDB
// snoop), then issues the lowest-index ready op in the issue phase.
// Capture phase (update_stat=1): snoop, dispatch, dispatch-time CDB bypass.
// Issue phase   (update_stat=0): select, register onto alu_* and free slot.
module alu_rs #(
  parameter int ENTRIES   = 8,
  parameter int IQ_ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 update_stat,
  input  logic                 clear_flag_in,
  input  logic                 dispatch_enable_in,
  input  logic [3:0]           dispatch_calc_code_in,
  input  logic                 dispatch_lhs_ready_in,
  input  logic                 dispatch_rhs_ready_in,
  input  logic [31:0]          dispatch_lhs_in,
  input  logic [31:0]          dispatch_rhs_in,
  input  logic [IQ_ADDR_W-1:0] dispatch_lhs_tag_in,
  input  logic [IQ_ADDR_W-1:0] dispatch_rhs_tag_in,
  input  logic [IQ_ADDR_W-1:0] dispatch_pos_in_iq_in,
  output logic                 rs_full_out,
  input  logic                 cdb_valid_in,
  input  logic [IQ_ADDR_W-1:0] cdb_tag_in,
  input  logic [31:0]          cdb_value_in,
  input  logic                 alu_full_in,
  output logic                 alu_calc_enable_out,
  output logic [3:0]           alu_calc_code_out,
  output logic [31:0]          alu_lhs_out,
  output logic [31:0]          alu_rhs_out,
  output logic [IQ_ADDR_W-1:0] alu_pos_in_iq_out
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W = $clog2(ENTRIES + 1);

  typedef struct packed {
    logic                 valid;
    logic [3:0]           code;
    logic                 lhs_ready;
    logic [31:0]          lhs_val;
    logic [IQ_ADDR_W-1:0] lhs_tag;
    logic                 rhs_ready;
    logic [31:0]          rhs_val;
    logic [IQ_ADDR_W-1:0] rhs_tag;
    logic [IQ_ADDR_W-1:0] pos;
  } entry_t;

  entry_t               ent_q [ENTRIES];
  entry_t               ent_d [ENTRIES];
  entry_t               new_ent;

  logic                 full_q,  full_d;
  logic                 en_q,    en_d;
  logic [3:0]           code_q,  code_d;
  logic [31:0]          lhs_q,   lhs_d;
  logic [31:0]          rhs_q,   rhs_d;
  logic [IQ_ADDR_W-1:0] pos_q,   pos_d;

  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic                 issue_found;
  logic [IDX_W-1:0]     issue_idx;
  logic [CNT_W-1:0]     valid_cnt;
  logic                 do_capture;
  logic                 do_issue;

  assign do_capture = rdy && !clear_flag_in && update_stat;
  assign do_issue   = rdy && !clear_flag_in && !update_stat && !(alu_full_in && clear_flag_in);

  // Lowest-index free slot (scan downwards so the lowest index wins).
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (!ent_q[i-1].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i - 1);
      end
    end
  end

  // Lowest-index valid entry with both operands ready.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (ent_q[i-1].valid && ent_q[i-1].lhs_ready && ent_q[i-1].rhs_ready) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i - 1);
      end
    end
  end

  // Incoming dispatch entry, with operands resolved by a same-cycle CDB.
  always_comb begin
    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.code      = dispatch_calc_code_in;
    new_ent.lhs_ready = dispatch_lhs_ready_in;
    new_ent.lhs_val   = dispatch_lhs_in;
    new_ent.lhs_tag   = dispatch_lhs_tag_in;
    new_ent.rhs_ready = dispatch_rhs_ready_in;
    new_ent.rhs_val   = dispatch_rhs_in;
    new_ent.rhs_tag   = dispatch_rhs_tag_in;
    new_ent.pos       = dispatch_pos_in_iq_in;
    if (cdb_valid_in && !dispatch_lhs_ready_in && dispatch_lhs_tag_in == cdb_tag_in) begin
      new_ent.lhs_ready = 1'b1;
      new_ent.lhs_val   = cdb_value_in;
    end
    if (cdb_valid_in && !dispatch_rhs_ready_in && dispatch_rhs_tag_in == cdb_tag_in) begin
      new_ent.rhs_ready = 1'b1;
      new_ent.rhs_val   = cdb_value_in;
    end
  end

  // Next-state for entries and issue outputs: clear > capture / issue.
  always_comb begin
    ent_d  = ent_q;
    en_d   = en_q;
    code_d = code_q;
    lhs_d  = lhs_q;
    rhs_d  = rhs_q;
    pos_d  = pos_q;
    if (rdy && clear_flag_in) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ent_d[i].valid = 1'b0;
      end
      en_d = 1'b0;
    end else if (do_capture) begin
      en_d = 1'b0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (cdb_valid_in && ent_q[i].valid) begin
          if (!ent_q[i].lhs_ready && ent_q[i].lhs_tag == cdb_tag_in) begin
            ent_d[i].lhs_ready = 1'b1;
            ent_d[i].lhs_val   = cdb_value_in;
          end
          if (!ent_q[i].rhs_ready && ent_q[i].rhs_tag == cdb_tag_in) begin
            ent_d[i].rhs_ready = 1'b1;
            ent_d[i].rhs_val   = cdb_value_in;
          end
        end
      end
      // A free slot is never snooped, so writing it after the snoop loop is safe.
      if (dispatch_enable_in && !full_q && free_found) begin
        ent_d[free_idx] = new_ent;
      end
    end else if (do_issue) begin
      if (issue_found) begin
        en_d                   = 1'b1;
        code_d                 = ent_q[issue_idx].code;
        lhs_d                  = ent_q[issue_idx].lhs_val;
        rhs_d                  = ent_q[issue_idx].rhs_val;
        pos_d                  = ent_q[issue_idx].pos;
        ent_d[issue_idx].valid = 1'b0;
      end else begin
        en_d = 1'b0;
      end
    end
  end

  // Occupancy of the next state drives the registered full flag.
  always_comb begin
    valid_cnt = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (ent_d[i].valid) begin
        valid_cnt = valid_cnt + CNT_W'(1);
      end
    end
    full_d = rdy ? (valid_cnt == CNT_W'(ENTRIES)) : full_q;
  end

  // State registers with synchronous reset; rdy=0 holds via the _d defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
      full_q <= 1'b0;
      en_q   <= 1'b0;
      code_q <= '0;
      lhs_q  <= '0;
      rhs_q  <= '0;
      pos_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ent_q[i] <= ent_d[i];
      end
      full_q <= full_d;
      en_q   <= en_d;
      code_q <= code_d;
      lhs_q  <= lhs_d;
      rhs_q  <= rhs_d;
      pos_q  <= pos_d;
    end
  end

  assign rs_full_out         = full_q;
  assign alu_calc_enable_out = en_q;
  assign alu_calc_code_out   = code_q;
  assign alu_lhs_out         = lhs_q;
  assign alu_rhs_out         = rhs_q;
  assign alu_pos_in_iq_out   = pos_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: randomized and directed bench for alu_rs against a queue-based
// model of pending ops (slot = lowest unused number, issue = lowest ready slot).
module tb_alu_rs;
  localparam int N  = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, update_stat, clear_flag_in;
  logic          dispatch_enable_in;
  logic [3:0]    dispatch_calc_code_in;
  logic          dispatch_lhs_ready_in, dispatch_rhs_ready_in;
  logic [31:0]   dispatch_lhs_in, dispatch_rhs_in;
  logic [TW-1:0] dispatch_lhs_tag_in, dispatch_rhs_tag_in, dispatch_pos_in_iq_in;
  logic          rs_full_out;
  logic          cdb_valid_in;
  logic [TW-1:0] cdb_tag_in;
  logic [31:0]   cdb_value_in;
  logic          alu_full_in;
  logic          alu_calc_enable_out;
  logic [3:0]    alu_calc_code_out;
  logic [31:0]   alu_lhs_out, alu_rhs_out;
  logic [TW-1:0] alu_pos_in_iq_out;

  always #5 clk = ~clk;

  alu_rs #(.ENTRIES(N), .IQ_ADDR_W(TW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .update_stat(update_stat),
    .clear_flag_in(clear_flag_in), .dispatch_enable_in(dispatch_enable_in),
    .dispatch_calc_code_in(dispatch_calc_code_in),
    .dispatch_lhs_ready_in(dispatch_lhs_ready_in), .dispatch_rhs_ready_in(dispatch_rhs_ready_in),
    .dispatch_lhs_in(dispatch_lhs_in), .dispatch_rhs_in(dispatch_rhs_in),
    .dispatch_lhs_tag_in(dispatch_lhs_tag_in), .dispatch_rhs_tag_in(dispatch_rhs_tag_in),
    .dispatch_pos_in_iq_in(dispatch_pos_in_iq_in), .rs_full_out(rs_full_out),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .alu_full_in(alu_full_in), .alu_calc_enable_out(alu_calc_enable_out),
    .alu_calc_code_out(alu_calc_code_out), .alu_lhs_out(alu_lhs_out),
    .alu_rhs_out(alu_rhs_out), .alu_pos_in_iq_out(alu_pos_in_iq_out)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          slot;
    logic [3:0]  code;
    bit          lr;
    logic [31:0] lv;
    logic [3:0]  lt;
    bit          rr;
    logic [31:0] rv;
    logic [3:0]  rt;
    logic [3:0]  pos;
  } op_t;

  op_t         pend[$];
  bit          m_en, m_full;
  logic [3:0]  m_code, m_pos;
  logic [31:0] m_lhs, m_rhs;

  logic [73:0] dut_vec;
  assign dut_vec = {alu_calc_enable_out, alu_calc_code_out, alu_lhs_out, alu_rhs_out,
                    alu_pos_in_iq_out, rs_full_out};

  function automatic logic [73:0] m_vec();
    return {m_en, m_code, m_lhs, m_rhs, m_pos, m_full};
  endfunction

  function automatic bit slot_used(int s);
    foreach (pend[k]) if (pend[k].slot == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    op_t o;
    int  best;
    int  s;
    if (rst) begin
      pend.delete();
      m_en = 0; m_code = '0; m_lhs = '0; m_rhs = '0; m_pos = '0; m_full = 0;
      return;
    end
    if (!rdy) return;
    if (clear_flag_in) begin
      pend.delete();
      m_en = 0;
    end else if (update_stat) begin
      m_en = 0;
      if (cdb_valid_in) begin
        foreach (pend[k]) begin
          if (!pend[k].lr && pend[k].lt == cdb_tag_in) begin pend[k].lr = 1; pend[k].lv = cdb_value_in; end
          if (!pend[k].rr && pend[k].rt == cdb_tag_in) begin pend[k].rr = 1; pend[k].rv = cdb_value_in; end
        end
      end
      if (dispatch_enable_in && !m_full) begin
        s = 0;
        while (slot_used(s)) s++;
        o.slot = s;
        o.code = dispatch_calc_code_in;
        o.lr = dispatch_lhs_ready_in; o.lv = dispatch_lhs_in; o.lt = dispatch_lhs_tag_in;
        o.rr = dispatch_rhs_ready_in; o.rv = dispatch_rhs_in; o.rt = dispatch_rhs_tag_in;
        o.pos = dispatch_pos_in_iq_in;
        if (!o.lr && cdb_valid_in && o.lt == cdb_tag_in) begin o.lr = 1; o.lv = cdb_value_in; end
        if (!o.rr && cdb_valid_in && o.rt == cdb_tag_in) begin o.rr = 1; o.rv = cdb_value_in; end
        pend.push_back(o);
      end
    end else begin
      best = -1;
      foreach (pend[k]) begin
        if (pend[k].lr && pend[k].rr && (best < 0 || pend[k].slot < pend[best].slot)) best = k;
      end
      if (best >= 0) begin
        m_en = 1; m_code = pend[best].code; m_lhs = pend[best].lv;
        m_rhs = pend[best].rv; m_pos = pend[best].pos;
        pend.delete(best);
      end else begin
        m_en = 0;
      end
    end
    m_full = (pend.size() == N);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    update_stat = ~update_stat;
  endtask

  task automatic idle_inputs();
    dispatch_enable_in = 0; cdb_valid_in = 0; clear_flag_in = 0;
  endtask

  task automatic to_capture();
    if (!update_stat) step();
  endtask

  task automatic set_dispatch(input logic [3:0] code, input bit lr, input logic [31:0] lv,
                              input logic [3:0] lt, input bit rr, input logic [31:0] rv,
                              input logic [3:0] rt, input logic [3:0] pos);
    dispatch_enable_in = 1; dispatch_calc_code_in = code;
    dispatch_lhs_ready_in = lr; dispatch_lhs_in = lv; dispatch_lhs_tag_in = lt;
    dispatch_rhs_ready_in = rr; dispatch_rhs_in = rv; dispatch_rhs_tag_in = rt;
    dispatch_pos_in_iq_in = pos;
  endtask

  task automatic set_cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid_in = 1; cdb_tag_in = tag; cdb_value_in = val;
  endtask

  task automatic do_reset();
    rst = 1; rdy = 1; update_stat = 1; alu_full_in = 0;
    idle_inputs();
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; rdy = 1; update_stat = 1; alu_full_in = 0;
    idle_inputs();
    set_dispatch(4'hF, 1, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF, 0, 4'hF);
    step(); step();
    checks++;
    if (dut_vec !== 74'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", dut_vec);
    end
    idle_inputs();
    rst = 0;
    step();
    checks++;
    if (dut_vec !== m_vec()) begin
      errors++; $display("FAIL reset_hold: got %h expected %h", dut_vec, m_vec());
    end
  endtask

  task automatic test_basic();
    int strobes = 0;
    int first_c = -1;
    logic [43:0] seen = '0;
    do_reset();
    to_capture();
    set_dispatch(4'd0, 1, 32'd5, 0, 1, 32'd7, 0, 4'd3);
    step();
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL basic_model c%0d: got %h expected %h", c, dut_vec, m_vec());
      end
      if (alu_calc_enable_out) begin
        strobes++;
        if (first_c < 0) first_c = c;
        seen = {alu_calc_code_out, alu_lhs_out[15:0], alu_rhs_out[15:0], 4'd0, alu_pos_in_iq_out};
      end
      checks++;
      if (rs_full_out !== 1'b0) begin
        errors++; $display("FAIL basic_full c%0d: got %b expected 0", c, rs_full_out);
      end
    end
    checks++;
    if (strobes != 1 || first_c != 0) begin
      errors++; $display("FAIL basic_strobe: got %0d strobes first at %0d, expected 1 at 0", strobes, first_c);
    end
    checks++;
    if (seen !== {4'd0, 16'd5, 16'd7, 4'd0, 4'd3}) begin
      errors++; $display("FAIL basic_values: got %h expected code0 lhs5 rhs7 pos3", seen);
    end
  endtask

  task automatic test_wakeup();
    int strobes = 0;
    do_reset();
    to_capture();
    set_dispatch(4'd1, 1, 32'd9, 0, 0, 32'hDEAD, 4'd6, 4'd5);
    step();
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      step();
      if (alu_calc_enable_out) strobes++;
    end
    to_capture();
    set_cdb(4'd5, 32'h55);
    step();
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      step();
      if (alu_calc_enable_out) strobes++;
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL wakeup_model c%0d: got %h expected %h", c, dut_vec, m_vec());
      end
    end
    checks++;
    if (strobes != 0) begin
      errors++; $display("FAIL wakeup_early: got %0d strobes expected 0", strobes);
    end
    to_capture();
    set_cdb(4'd6, 32'd2);
    step();
    idle_inputs();
    step();
    checks++;
    if ({alu_calc_enable_out, alu_calc_code_out, alu_lhs_out, alu_rhs_out, alu_pos_in_iq_out}
        !== {1'b1, 4'd1, 32'd9, 32'd2, 4'd5}) begin
      errors++; $display("FAIL wakeup_issue: got en%b code%0d lhs%0d rhs%0d pos%0d expected en1 code1 lhs9 rhs2 pos5",
                         alu_calc_enable_out, alu_calc_code_out, alu_lhs_out, alu_rhs_out, alu_pos_in_iq_out);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    to_capture();
    set_dispatch(4'd2, 1, 32'd3, 0, 0, 32'hBAD, 4'd4, 4'd7);
    set_cdb(4'd4, 32'h10);
    step();
    idle_inputs();
    step();
    checks++;
    if ({alu_calc_enable_out, alu_calc_code_out, alu_lhs_out, alu_rhs_out, alu_pos_in_iq_out}
        !== {1'b1, 4'd2, 32'd3, 32'h10, 4'd7}) begin
      errors++; $display("FAIL bypass_issue: got en%b lhs%h rhs%h expected en1 lhs3 rhs10",
                         alu_calc_enable_out, alu_lhs_out, alu_rhs_out);
    end
    checks++;
    if (dut_vec !== m_vec()) begin
      errors++; $display("FAIL bypass_model: got %h expected %h", dut_vec, m_vec());
    end
  endtask

  task automatic test_fill();
    logic [3:0] got[$];
    bit full_checked = 0;
    do_reset();
    for (int s = 0; s < N; s++) begin
      to_capture();
      set_dispatch(4'(s), 1, 32'(s * 11), 0, 0, 32'h0, 4'd1, 4'(s));
      step();
      idle_inputs();
    end
    step();
    checks++;
    if (rs_full_out !== 1'b1) begin
      errors++; $display("FAIL fill_full: got %b expected 1", rs_full_out);
    end
    to_capture();
    set_dispatch(4'hE, 1, 32'd1, 0, 1, 32'd1, 0, 4'hF);
    step();
    idle_inputs();
    step();
    checks++;
    if (alu_calc_enable_out !== 1'b0 || dut_vec !== m_vec()) begin
      errors++; $display("FAIL fill_drop: got %h expected %h", dut_vec, m_vec());
    end
    to_capture();
    set_cdb(4'd1, 32'hABC);
    step();
    idle_inputs();
    for (int c = 0; c < 2 * N + 2; c++) begin
      step();
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL fill_model c%0d: got %h expected %h", c, dut_vec, m_vec());
      end
      if (alu_calc_enable_out) begin
        got.push_back(alu_pos_in_iq_out);
        if (!full_checked) begin
          full_checked = 1;
          checks++;
          if (rs_full_out !== 1'b0) begin
            errors++; $display("FAIL fill_full_clear: got %b expected 0", rs_full_out);
          end
        end
      end
    end
    checks++;
    if (got.size() != N) begin
      errors++; $display("FAIL fill_count: got %0d issues expected %0d", got.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (got[i] !== 4'(i)) begin
          errors++; $display("FAIL fill_order%0d: got pos %0d expected %0d", i, got[i], i);
        end
      end
    end
  endtask

  task automatic test_clear();
    int strobes = 0;
    logic [3:0] got[$];
    do_reset();
    for (int s = 0; s < 4; s++) begin
      to_capture();
      set_dispatch(4'd3, 1, 32'(s), 0, 0, 32'h0, 4'd2, 4'(8 + s));
      step();
      idle_inputs();
    end
    to_capture();
    set_cdb(4'd2, 32'h77);
    step();
    idle_inputs();
    step();
    checks++;
    if (alu_calc_enable_out !== 1'b1 || alu_pos_in_iq_out !== 4'd8) begin
      errors++; $display("FAIL clear_pre: got en%b pos%0d expected en1 pos8", alu_calc_enable_out, alu_pos_in_iq_out);
    end
    clear_flag_in = 1;
    step();
    clear_flag_in = 0;
    checks++;
    if (alu_calc_enable_out !== 1'b0 || rs_full_out !== 1'b0) begin
      errors++; $display("FAIL clear_now: got en%b full%b expected en0 full0", alu_calc_enable_out, rs_full_out);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      if (alu_calc_enable_out) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++; $display("FAIL clear_quiet: got %0d strobes expected 0", strobes);
    end
    to_capture();
    set_dispatch(4'd4, 1, 32'd1, 0, 0, 32'h0, 4'd9, 4'd1);
    step();
    idle_inputs();
    to_capture();
    set_dispatch(4'd4, 1, 32'd2, 0, 0, 32'h0, 4'd9, 4'd2);
    step();
    idle_inputs();
    to_capture();
    set_cdb(4'd9, 32'h99);
    step();
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL clear_model c%0d: got %h expected %h", c, dut_vec, m_vec());
      end
      if (alu_calc_enable_out) got.push_back(alu_pos_in_iq_out);
    end
    checks++;
    if (got.size() != 2 || got[0] !== 4'd1 || got[1] !== 4'd2) begin
      errors++; $display("FAIL clear_after: got %0d issues, expected pos1 then pos2", got.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 0; c < 48; c++) begin
      idle_inputs();
      rdy = !(c >= 16 && c < 20);
      if ((update_stat && $urandom_range(0, 2) != 0) || !rdy)
        set_dispatch(4'($urandom), 1'($urandom), $urandom, 4'($urandom_range(0, 3)),
                     1'($urandom), $urandom, 4'($urandom_range(0, 3)), 4'($urandom));
      if (update_stat && $urandom_range(0, 1) == 1 || !rdy)
        set_cdb(4'($urandom_range(0, 3)), $urandom);
      if (!rdy) clear_flag_in = 1'($urandom);
      step();
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL stall_model c%0d: got %h expected %h", c, dut_vec, m_vec());
      end
    end
    rdy = 1;
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      rdy = ($urandom_range(0, 9) != 0);
      alu_full_in = 1'($urandom);
      clear_flag_in = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) != 0)
        set_dispatch(4'($urandom), 1'($urandom), $urandom, 4'($urandom_range(0, 5)),
                     1'($urandom), $urandom, 4'($urandom_range(0, 5)), 4'($urandom));
      if ($urandom_range(0, 2) == 0)
        set_cdb(4'($urandom_range(0, 5)), $urandom);
      step();
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL random_model c%0d: got %h expected %h", c, dut_vec, m_vec());
      end
    end
    rdy = 1;
    idle_inputs();
  endtask

  initial begin
    rst = 1; rdy = 1; update_stat = 1; alu_full_in = 0;
    dispatch_enable_in = 0; dispatch_calc_code_in = '0;
    dispatch_lhs_ready_in = 0; dispatch_rhs_ready_in = 0;
    dispatch_lhs_in = '0; dispatch_rhs_in = '0;
    dispatch_lhs_tag_in = '0; dispatch_rhs_tag_in = '0; dispatch_pos_in_iq_in = '0;
    cdb_valid_in = 0; cdb_tag_in = '0; cdb_value_in = '0; clear_flag_in = 0;
    m_en = 0; m_full = 0; m_code = '0; m_pos = '0; m_lhs = '0; m_rhs = '0;
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_fill();
    test_clear();
    test_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station feeding the integer ALU. It accepts decoded arithmetic, logic and branch-compare ops from dispatch and holds them until both operands are resolved. Resolution comes from the dispatch values or from snooping the CDB. It then issues one ready op per issue window to the ALU over the calc interface (enable, code, lhs, rhs, IQ position), using the ALU's full flag as back-pressure. It sits between dispatch/rename and the ALU, on the same two-phase update_stat schedule as the ALU.

## Interface
- ENTRIES, 8: number of station slots (power of two, ≥2)
- IQ_ADDR_W, 4: width of instruction-queue index / rename tag
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global stall; low = hold all state and outputs
- update_stat  in  1  phase flag; alternates 1/0 every cycle
- clear_flag_in  in  1  flush (mispredict); invalidates all entries
- dispatch_enable_in  in  1  write a new entry (only sampled when update_stat=1)
- dispatch_calc_code_in  in  4  ALU op code 0..15 (ALU encoding)
- dispatch_lhs_ready_in, dispatch_rhs_ready_in  in  1  operand already valid
- dispatch_lhs_in, dispatch_rhs_in  in  32  operand value when ready
- dispatch_lhs_tag_in, dispatch_rhs_tag_in  in  IQ_ADDR_W  producer IQ index when not ready
- dispatch_pos_in_iq_in  in  IQ_ADDR_W  IQ index of this op
- rs_full_out  out  1  all ENTRIES slots valid; dispatch must not assert
- cdb_valid_in  in  1  CDB broadcast valid
- cdb_tag_in  in  IQ_ADDR_W  producer IQ index
- cdb_value_in  in  32  broadcast result
- alu_full_in  in  1  ALU holds an undrained result
- alu_calc_enable_out  out  1  issue strobe to ALU
- alu_calc_code_out  out  4  op code
- alu_lhs_out, alu_rhs_out  out  32  operands
- alu_pos_in_iq_out  out  IQ_ADDR_W  IQ index of issued op

## Operation
- Per entry: valid, code, lhs_ready/lhs_val/lhs_tag, rhs_ready/rhs_val/rhs_tag, pos.
- Capture phase (rdy, update_stat=1, !clear_flag_in):
  - CDB snoop: every valid entry with an operand not ready and tag==cdb_tag_in takes cdb_value_in and sets ready.
  - Dispatch: write into the lowest-index invalid slot.
  - CDB bypass: a dispatched operand not ready whose tag matches a same-cycle valid CDB is written ready with cdb_value_in.
- Issue phase (rdy, update_stat=0, !clear_flag_in, !(alu_full_in && clear_flag_in)):
  - Select the lowest-index valid entry with both operands ready.
  - Register it onto the alu_* outputs with alu_calc_enable_out=1 and invalidate the slot.
  - If no entry qualifies, alu_calc_enable_out=0.
- The ALU drains its result in every non-update cycle without clear, so issue is never blocked on alu_full_in outside a flush.
- Any capture-phase edge: alu_calc_enable_out←0; data outputs hold their last values.
- clear_flag_in (any rdy cycle): all valid←0, alu_calc_enable_out←0. Clear has priority over dispatch, snoop and issue.
- rs_full_out = (valid count == ENTRIES), registered and updated every rdy edge. A dispatch with rs_full_out=1 is a protocol error and is dropped.
- rdy=0: no state change, outputs held.
- Reset: all valid←0, rs_full_out←0, alu_calc_enable_out←0, alu_calc_code_out←0, alu_lhs_out←0, alu_rhs_out←0, alu_pos_in_iq_out←0.

## Timing
- Issue strobe is registered at the issue-phase edge. It is high for exactly the following update_stat=1 cycle, which is when the ALU samples it, and drops at the next edge.
- Dispatch-to-issue latency with both operands ready: dispatch at capture edge N, issue edge N+1, strobe visible in cycle N+2 (ALU samples at edge N+2).
- Operand woken by CDB at capture edge N is eligible at issue edge N+1.
- A slot freed at an issue edge is reusable at the next capture edge; rs_full_out deasserts at the freeing edge.
- At most one dispatch and one issue per two-cycle window.

## Test plan
- Reset, then dispatch code 0, lhs=5, rhs=7, both ready, pos=3. Required: single strobe in the update_stat=1 cycle two cycles later with code=0, lhs=5, rhs=7, pos=3; rs_full_out=0 throughout.
- Dispatch code 1, lhs ready=9, rhs tag=6 not ready. No issue until CDB tag=6 value=2; then the op issues with rhs=2 in the next window. A CDB with tag=5 must not wake it.
- Dispatch with rhs tag=4 in the same capture cycle as CDB valid tag=4 value=0x10. Required: issue in the next window with rhs=0x10 (bypass).
- Fill 8 entries, all blocked on tag=1. Required: rs_full_out=1. Broadcast CDB tag=1. Required: issue order is slots 0..7 over 8 windows, and rs_full_out clears after the first issue.
- With 3 ready entries and a pending strobe, assert clear_flag_in for one cycle. Required: strobe low next edge, no further issues, rs_full_out=0, and a new dispatch lands in slot 0.
- Hold rdy=0 for 4 cycles mid-stream. Required: outputs and entries frozen, and issue order and values are identical to the run without the stall.
